// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: dmem stores feed a TX FIFO that is shifted out LSB first.
// Four registers (TXDATA, STATUS, BAUDDIV, CTRL) sit at BASE_ADDR..BASE_ADDR+3.
module mmio_uart_tx #(
    parameter logic [11:0] BASE_ADDR   = 12'hFF0,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_mmio,
    output logic        hit,
    output logic        tx,
    output logic        tx_active
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overrun;
    logic [15:0]   r_div;
    logic          r_enable;
    logic [15:0]   r_div_active;
    logic [15:0]   r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;

    logic [15:0]   w_div_active_nx;
    logic [15:0]   w_cnt_nx;
    logic [2:0]    w_bit_nx;
    logic [7:0]    w_shift_nx;
    logic          w_pop;
    logic          w_can_pop;

    logic          w_hit;
    logic [1:0]    w_off;
    logic          w_wr;
    logic          w_push_req;
    logic          w_push_ok;
    logic          w_flush;
    logic          w_ovr_clr;
    logic          w_full;
    logic          w_empty;
    logic [15:0]   w_div_wdata;
    logic [4:0]    w_count5;
    logic [7:0]    w_head;
    logic          w_unused_data;

    assign w_hit         = (address_dmem[11:2] == BASE_ADDR[11:2]);
    assign w_off         = address_dmem[1:0];
    assign w_wr          = wren & w_hit;
    assign w_push_req    = w_wr && (w_off == 2'd0);
    assign w_ovr_clr     = w_wr && (w_off == 2'd1) && data[3];
    assign w_flush       = w_wr && (w_off == 2'd3) && data[1];
    assign w_full        = (r_count == CNT_FULL);
    assign w_empty       = (r_count == '0);
    assign w_push_ok     = w_push_req && (!w_full || w_pop);
    assign w_div_wdata   = (data[15:0] < 16'd2) ? 16'd2 : data[15:0];
    assign w_count5      = 5'(r_count);
    assign w_head        = r_mem[r_rd_ptr];
    assign w_can_pop     = r_enable && !w_empty;
    assign w_unused_data = ^data[31:16];

    assign hit       = w_hit;
    assign tx_active = (r_state != S_IDLE);

    always_comb begin
        q_mmio = 32'd0;
        if (w_hit) begin
            case (w_off)
                2'd1:    q_mmio = {19'd0, w_count5, 4'd0, r_overrun, tx_active, w_empty, w_full};
                2'd2:    q_mmio = {16'd0, r_div};
                2'd3:    q_mmio = {31'd0, r_enable};
                default: q_mmio = 32'd0;
            endcase
        end
    end

    // Flush wins over everything; the in-flight frame lives in r_shift and is unaffected.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_ONE;
                case ({w_push_ok, w_pop})
                    2'b10:   r_count <= r_count + CNT_ONE;
                    2'b01:   r_count <= r_count - CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
            if (w_push_req && w_full && !w_pop) r_overrun <= 1'b1;
            else if (w_ovr_clr)                 r_overrun <= 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_push_ok && !w_flush) r_mem[r_wr_ptr] <= data[7:0];
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_div    <= DEFAULT_DIV;
            r_enable <= 1'b1;
        end else begin
            if (w_wr && (w_off == 2'd2)) r_div    <= w_div_wdata;
            if (w_wr && (w_off == 2'd3)) r_enable <= data[0];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_div_active <= DEFAULT_DIV;
            r_cnt        <= 16'd0;
            r_bit        <= 3'd0;
            r_shift      <= 8'd0;
        end else begin
            r_state      <= w_state_nx;
            r_div_active <= w_div_active_nx;
            r_cnt        <= w_cnt_nx;
            r_bit        <= w_bit_nx;
            r_shift      <= w_shift_nx;
        end
    end

    // Each bit lasts div_active cycles: the counter runs div_active-1 down to 0.
    always_comb begin
        w_state_nx      = r_state;
        w_div_active_nx = r_div_active;
        w_cnt_nx        = r_cnt;
        w_bit_nx        = r_bit;
        w_shift_nx      = r_shift;
        w_pop           = 1'b0;
        tx              = 1'b1;
        case (r_state)
            S_IDLE: begin
                tx = 1'b1;
                if (w_can_pop) begin
                    w_pop           = 1'b1;
                    w_shift_nx      = w_head;
                    w_div_active_nx = r_div;
                    w_cnt_nx        = r_div - 16'd1;
                    w_state_nx      = S_START;
                end
            end
            S_START: begin
                tx = 1'b0;
                if (r_cnt == 16'd0) begin
                    w_cnt_nx   = r_div_active - 16'd1;
                    w_bit_nx   = 3'd0;
                    w_state_nx = S_DATA;
                end else begin
                    w_cnt_nx = r_cnt - 16'd1;
                end
            end
            S_DATA: begin
                tx = r_shift[0];
                if (r_cnt == 16'd0) begin
                    w_cnt_nx   = r_div_active - 16'd1;
                    w_shift_nx = {1'b0, r_shift[7:1]};
                    w_bit_nx   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_nx = S_STOP;
                end else begin
                    w_cnt_nx = r_cnt - 16'd1;
                end
            end
            S_STOP: begin
                tx = 1'b1;
                if (r_cnt == 16'd0) begin
                    if (w_can_pop) begin
                        w_pop           = 1'b1;
                        w_shift_nx      = w_head;
                        w_div_active_nx = r_div;
                        w_cnt_nx        = r_div - 16'd1;
                        w_state_nx      = S_START;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_cnt_nx = r_cnt - 16'd1;
                end
            end
            default: begin
                tx         = 1'b1;
                w_state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register map, frame shape and timing, FIFO overrun, flush, reset.
module tb_mmio_uart_tx;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_mmio;
    logic        hit;
    logic        tx;
    logic        tx_active;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [11:0] A_TXDATA = 12'hFF0;
    localparam logic [11:0] A_STATUS = 12'hFF1;
    localparam logic [11:0] A_DIV    = 12'hFF2;
    localparam logic [11:0] A_CTRL   = 12'hFF3;

    mmio_uart_tx dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_mmio       (q_mmio),
        .hit          (hit),
        .tx           (tx),
        .tx_active    (tx_active)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge CLOCK_50);
        address_dmem = a;
        data         = d;
        wren         = 1'b1;
        @(posedge CLOCK_50);
        #1;
        wren = 1'b0;
    endtask

    task automatic rd_chk(input logic [11:0] a, input logic [31:0] exp, input string tag);
        @(negedge CLOCK_50);
        address_dmem = a;
        wren         = 1'b0;
        #1;
        check(tag, q_mmio, exp);
    endtask

    // Call 1 time unit after the edge that popped the byte; returns 1 unit after the frame's last edge.
    task automatic check_frame(input logic [7:0] b, input int div, input string tag);
        logic [159:0] obs;
        logic [159:0] exp;
        logic [9:0]   fr;
        logic         act_ok;
        fr     = {1'b1, b, 1'b0};
        obs    = '0;
        exp    = '0;
        act_ok = 1'b1;
        for (int i = 0; i < 10 * div; i++) begin
            obs[i] = tx;
            exp[i] = fr[i / div];
            if (tx_active !== 1'b1) act_ok = 1'b0;
            @(posedge CLOCK_50);
            #1;
        end
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        check({tag, "_active"}, {31'd0, act_ok}, 32'd1);
    endtask

    logic [7:0] bytes9 [9];

    initial begin
        bytes9[0] = 8'h00; bytes9[1] = 8'hFF; bytes9[2] = 8'h55;
        bytes9[3] = 8'hAA; bytes9[4] = 8'h0F; bytes9[5] = 8'hF0;
        bytes9[6] = 8'h81; bytes9[7] = 8'h7E; bytes9[8] = 8'hC3;

        reset        = 1'b0;
        wren         = 1'b0;
        address_dmem = 12'h000;
        data         = 32'd0;
        #1;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_active", {31'd0, tx_active}, 32'd0);
        repeat (3) @(posedge CLOCK_50);
        #2 reset = 1'b1;

        rd_chk(A_STATUS, 32'h0000_0002, "rst_status");
        check("hit_in_window", {31'd0, hit}, 32'd1);
        rd_chk(A_DIV, 32'd434, "rst_div");
        rd_chk(A_CTRL, 32'd1, "rst_ctrl");
        rd_chk(A_TXDATA, 32'd0, "txdata_reads0");

        // Single frame at 4 clocks per bit.
        wr(A_DIV, 32'd4);
        wr(A_TXDATA, 32'h0000_00A5);
        @(posedge CLOCK_50);
        #1;
        check_frame(8'hA5, 4, "frame_a5");
        check("a5_idle_after", {31'd0, tx_active}, 32'd0);
        check("a5_tx_idle", {31'd0, tx}, 32'd1);

        // Fill while disabled, overrun, clear, then 8 back-to-back frames.
        wr(A_DIV, 32'd2);
        wr(A_CTRL, 32'd0);
        for (int i = 0; i < 9; i++) wr(A_TXDATA, {24'd0, bytes9[i]});
        rd_chk(A_STATUS, 32'h0000_0809, "full_overrun");
        wr(A_STATUS, 32'h0000_0008);
        rd_chk(A_STATUS, 32'h0000_0801, "overrun_clear");
        rd_chk(A_CTRL, 32'd0, "ctrl_disabled");
        wr(A_CTRL, 32'd1);
        @(posedge CLOCK_50);
        #1;
        for (int i = 0; i < 8; i++) check_frame(bytes9[i], 2, $sformatf("b2b_%0d", i));
        check("b2b_done_idle", {31'd0, tx_active}, 32'd0);
        rd_chk(A_STATUS, 32'h0000_0002, "b2b_empty");

        // BAUDDIV change mid-frame only affects the following frame.
        wr(A_DIV, 32'd4);
        wr(A_TXDATA, 32'h0000_003C);
        wr(A_TXDATA, 32'h0000_00C5);
        fork
            check_frame(8'h3C, 4, "div_keep4");
            begin
                repeat (16) @(posedge CLOCK_50);
                wr(A_DIV, 32'd8);
            end
        join
        check_frame(8'hC5, 8, "div_new8");
        check("div_idle_after", {31'd0, tx_active}, 32'd0);
        wr(A_DIV, 32'd0);
        rd_chk(A_DIV, 32'd2, "div_min_0");
        wr(A_DIV, 32'd1);
        rd_chk(A_DIV, 32'd2, "div_min_1");
        wr(A_DIV, 32'd4);

        // Flush during frame 1 of 3 queued bytes.
        wr(A_CTRL, 32'd0);
        wr(A_TXDATA, 32'h0000_0011);
        wr(A_TXDATA, 32'h0000_0022);
        wr(A_TXDATA, 32'h0000_0033);
        wr(A_CTRL, 32'd1);
        @(posedge CLOCK_50);
        #1;
        fork
            check_frame(8'h11, 4, "flush_frame1");
            begin
                repeat (8) @(posedge CLOCK_50);
                wr(A_CTRL, 32'd3);
            end
        join
        check("flush_idle", {31'd0, tx_active}, 32'd0);
        rd_chk(A_STATUS, 32'h0000_0002, "flush_empty");
        repeat (30) @(posedge CLOCK_50);
        #1;
        check("flush_no_more", {31'd0, tx_active}, 32'd0);

        // Asynchronous reset in the middle of the data bits.
        wr(A_TXDATA, 32'h0000_0000);
        @(posedge CLOCK_50);
        #1;
        repeat (6) @(posedge CLOCK_50);
        #1;
        check("mid_data_tx0", {31'd0, tx}, 32'd0);
        check("mid_data_active", {31'd0, tx_active}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_tx", {31'd0, tx}, 32'd1);
        check("async_rst_active", {31'd0, tx_active}, 32'd0);
        address_dmem = A_STATUS;
        #1;
        check("async_rst_status", q_mmio, 32'h0000_0002);
        #13 reset = 1'b1;
        rd_chk(A_DIV, 32'd434, "post_rst_div");
        rd_chk(A_STATUS, 32'h0000_0002, "post_rst_status");
        wr(A_DIV, 32'd4);
        wr(A_TXDATA, 32'h0000_0096);
        @(posedge CLOCK_50);
        #1;
        check_frame(8'h96, 4, "post_rst_frame");
        check("post_rst_idle", {31'd0, tx_active}, 32'd0);

        // Accesses just outside the window must not hit or change state.
        @(negedge CLOCK_50);
        address_dmem = 12'hFEF;
        data         = 32'h0000_0002;
        wren         = 1'b1;
        #1;
        check("out_hit", {31'd0, hit}, 32'd0);
        check("out_q", q_mmio, 32'd0);
        @(posedge CLOCK_50);
        #1;
        wren = 1'b0;
        wr(12'hFF4, 32'h0000_0055);
        wr(12'hFEE, 32'h0000_0000);
        wr(12'h100, 32'h0000_0008);
        rd_chk(A_CTRL, 32'd1, "out_ctrl_kept");
        rd_chk(A_DIV, 32'd4, "out_div_kept");
        rd_chk(A_STATUS, 32'h0000_0002, "out_status_kept");
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("out_no_tx", {31'd0, tx_active}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
